// File: rtl/banked_dmem.sv
// Banked RV32 data memory with valid/ready request/response handshake,
// byte/half/word lane handling, load extension and access error reporting.
module banked_dmem #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WORDS = 512,
  localparam int ADDR_W    = $clog2(NUM_BANKS * BANK_WORDS) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int BB     = $clog2(NUM_BANKS);
  localparam int BSEL_W = (BB > 0) ? BB : 1;
  localparam int WIDX_W = $clog2(BANK_WORDS);

  logic              accept;
  logic [BSEL_W-1:0] bank_sel;
  logic [WIDX_W-1:0] widx;
  logic [1:0]        lane;
  logic              err;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       bank_rd [NUM_BANKS];

  logic              write_q, err_q;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic [BSEL_W-1:0] bank_q;
  logic [31:0]       rd_word, rd_shift, load_val;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign widx      = req_addr[WIDX_W+1:2];
  assign lane      = req_addr[1:0];

  if (BB > 0) begin : g_bsel
    assign bank_sel = req_addr[ADDR_W-1 -: BSEL_W];
  end else begin : g_bsel_single
    assign bank_sel = '0;
  end

  always_comb begin
    err = 1'b0;
    case (req_funct3)
      3'b000:  err = 1'b0;
      3'b100:  err = req_write;
      3'b001:  err = lane[0];
      3'b101:  err = lane[0] || req_write;
      3'b010:  err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so each enabled lane picks its own copy.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {lane[1], 1'b0};
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!req_write || err) be = 4'b0000;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [31:0] mem [BANK_WORDS];
    logic [31:0] rd_q;
    logic        sel;

    assign sel = accept && (bank_sel == BSEL_W'(b));

    // Read port only moves on an accepted load, so stalled responses stay stable.
    always_ff @(posedge clk) begin
      if (sel) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
        if (!req_write) rd_q <= mem[widx];
      end
    end

    assign bank_rd[b] = rd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      f3_q       <= 3'b000;
      lane_q     <= 2'b00;
      bank_q     <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      write_q    <= req_write;
      err_q      <= err;
      f3_q       <= req_funct3;
      lane_q     <= lane;
      bank_q     <= bank_sel;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign rd_word  = bank_rd[bank_q];
  assign rd_shift = rd_word >> {lane_q, 3'b000};

  always_comb begin
    load_val = rd_shift;
    case (f3_q)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_val = {24'h000000, rd_shift[7:0]};
      3'b101:  load_val = {16'h0000, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !write_q && !err_q) ? load_val : 32'h0000_0000;

endmodule

// File: tb/tb_banked_dmem.sv
// Self-checking bench for banked_dmem: directed cases plus randomized traffic
// checked against a byte-addressed reference memory.
module tb_banked_dmem;

  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  banked_dmem dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] bm [int];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit access_err(input bit w, input logic [2:0] f3, input int a);
    case (f3)
      3'd0:    return 1'b0;
      3'd4:    return w;
      3'd1:    return (a % 2) != 0;
      3'd5:    return w || ((a % 2) != 0);
      3'd2:    return (a % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t model(input bit w, input logic [2:0] f3, input int a, input logic [31:0] wd);
    exp_t        e;
    int          n;
    logic [31:0] v;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.err   = access_err(w, f3, a);
    e.rdata = 32'h0;
    if (!e.err) begin
      if (w) begin
        for (int i = 0; i < n; i++) bm[a + i] = 8'(wd >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(bm[a + i]) << (8 * i));
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        e.rdata = v;
      end
    end
    return e;
  endfunction

  task automatic step(input bit v, input bit w, input logic [2:0] f3, input int a,
                      input logic [31:0] wd, input bit rr);
    bit exp_ready;
    bit acc;
    @(negedge clk);
    resp_ready = rr;
    exp_ready  = (exp_q.size() == 0) || rr;
    if (exp_q.size() > 0) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_rdata", resp_rdata, exp_q[0].rdata);
      chk("resp_err", resp_err, exp_q[0].err);
      if (rr) void'(exp_q.pop_front());
    end else begin
      chk("resp_idle", resp_valid, 0);
    end
    req_valid  = v;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = ADDR_W'(a);
    req_wdata  = wd;
    #1;
    chk("req_ready", req_ready, exp_ready);
    acc = v && exp_ready;
    @(posedge clk);
    if (acc) exp_q.push_back(model(w, f3, a, wd));
  endtask

  initial begin
    int a, word, lane;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a held response
    step(1, 1, 3'd2, 'h010, 32'h1122_3344, 1);
    step(1, 0, 3'd2, 'h010, 0, 1);
    step(0, 0, 3'd0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_resp_rdata", resp_rdata, 0);
    chk("midrst_resp_err", resp_err, 0);
    exp_q.delete();
    @(negedge clk);
    reset      = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("postrst_req_ready", req_ready, 1);
    step(1, 0, 3'd2, 'h010, 0, 1);

    // Word store, then loads of the same word on the following cycles
    step(1, 1, 3'd2, 'h004, 32'h8000_00F0, 1);
    step(1, 0, 3'd2, 'h004, 0, 1);
    step(1, 0, 3'd0, 'h004, 0, 1);
    step(1, 0, 3'd4, 'h007, 0, 1);

    // Byte store into bank 1
    step(1, 1, 3'd2, 'h804, 32'hAABB_CCDD, 1);
    step(1, 1, 3'd0, 'h805, 32'h0000_0012, 1);
    step(1, 0, 3'd2, 'h804, 0, 1);
    step(1, 0, 3'd5, 'h806, 0, 1);
    step(1, 0, 3'd2, 'h004, 0, 1);
    step(1, 1, 3'd1, 'h806, 32'h0000_9876, 1);
    step(1, 0, 3'd1, 'h806, 0, 1);
    step(1, 0, 3'd0, 'h807, 0, 1);

    // Error cases must not touch memory
    step(1, 0, 3'd1, 'h003, 0, 1);
    step(1, 1, 3'd2, 'h002, 32'hDEAD_BEEF, 1);
    step(1, 0, 3'd3, 'h004, 0, 1);
    step(1, 1, 3'd4, 'h004, 32'h0000_0055, 1);
    step(1, 1, 3'd5, 'h804, 32'h0000_5555, 1);
    step(1, 1, 3'd7, 'h004, 32'h1234_5678, 1);
    step(1, 0, 3'd2, 'h004, 0, 1);
    step(1, 0, 3'd2, 'h804, 0, 1);

    // Backpressure then a burst of back-to-back reads
    step(1, 0, 3'd2, 'h004, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 3'd2, 'h804, 0, 0);
    step(1, 0, 3'd2, 'h804, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 3'd2, (i % 2 == 0) ? 'h004 : 'h804, 0, 1);

    // Bank sweep: first and last word of every bank
    for (int b = 0; b < 4; b++) begin
      step(1, 1, 3'd2, b * 2048, 32'hB000_0000 | (b << 16) | (b * 2048), 1);
      step(1, 1, 3'd2, b * 2048 + 2044, 32'hB000_0000 | (b << 16) | (b * 2048 + 2044), 1);
    end
    for (int b = 0; b < 4; b++) begin
      step(1, 0, 3'd2, b * 2048, 0, 1);
      step(1, 0, 3'd2, b * 2048 + 2044, 0, 1);
    end

    // Randomized traffic over a preloaded region spanning all banks
    for (int k = 0; k < 16; k++)
      step(1, 1, 3'd2, (k / 4) * 2048 + 'h40 + (k % 4) * 4, $urandom, 1);
    for (int k = 0; k < 300; k++) begin
      word = $urandom_range(0, 15);
      lane = $urandom_range(0, 3);
      a    = (word / 4) * 2048 + 'h40 + (word % 4) * 4 + lane;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
           a, $urandom, $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 16; k++)
      step(1, 0, 3'd2, (k / 4) * 2048 + 'h40 + (k % 4) * 4, 0, 1);

    step(0, 0, 3'd0, 0, 0, 1);
    step(0, 0, 3'd0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
